decode_hazard_controller: RTL and testbench

Interlock controller for the decode stage: tracks destination registers of instructions in flight in EXE, MEM and WB, detects source operands that forwarding cannot yet supply, and drives the decode stage's `status_backwards_in` with READY/STALL/JUMP. It sits between the execute-side pipeline control and `decode_stage`. It inserts interlock bubbles so that loads, CSR reads and other late-result instructions resolve correctly through the existing EXE/MEM/WB forwarding paths. It also keeps a stall-cycle performance counter.

---
 rtl/decode_hazard_controller_pkg.sv | 35 +++
 rtl/pipeline_status_pkg.sv | 12 +
 rtl/decode_hazard_controller_slot_match.sv | 33 +++
 rtl/decode_hazard_controller.sv | 109 ++++++++++
 tb/tb_decode_hazard_controller.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_hazard_controller_pkg.sv
// Types and helpers for the decode interlock: in-flight slot entries and result stages.
// Latency: n/a (type definitions and pure functions only).
// Backpressure: n/a.
package hazard;

    // Stage whose forwarding port first carries an instruction's result.
    typedef enum logic [1:0] {
        RES_EXE = 2'd0,
        RES_MEM = 2'd1,
        RES_WB  = 2'd2
    } result_stage_t;

    typedef struct packed {
        logic          valid;
        logic [4:0]    rd;
        result_stage_t result_stage;
    } entry_t;

    localparam entry_t EMPTY_ENTRY = '{valid: 1'b0, rd: 5'd0, result_stage: RES_EXE};

    localparam logic [1:0] SLOT_EXE = 2'd0;
    localparam logic [1:0] SLOT_MEM = 2'd1;
    localparam logic [1:0] SLOT_WB  = 2'd2;

    // Numeric stage rank; the illegal encoding 3 is treated as WB.
    function automatic logic [1:0] stage_rank(input result_stage_t s);
        return s[1] ? 2'd2 : {1'b0, s[0]};
    endfunction

    // An entry sitting in slot 'slot' cannot forward yet if its result appears in a later stage.
    function automatic logic unresolved(input entry_t e, input logic [1:0] slot);
        return e.valid && (e.rd != 5'd0) && (stage_rank(e.result_stage) > slot);
    endfunction

endpackage

// File: rtl/pipeline_status_pkg.sv
// Pipeline handshake status passed backwards from a stage to its upstream neighbour.
// Latency: n/a (type definitions only).
// Backpressure: STALL holds the upstream stage; JUMP squashes it.
package pipeline_status;

    typedef enum logic [1:0] {
        READY = 2'd0,
        STALL = 2'd1,
        JUMP  = 2'd2
    } backwards_t;

endpackage

// File: rtl/decode_hazard_controller_slot_match.sv
// Checks one source register against the EXE/MEM/WB slots; flags a source forwarding cannot supply.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
module hazard_slot_match
    import hazard::*;
(
    input  logic [4:0] src,
    input  entry_t     exe_slot,
    input  entry_t     mem_slot,
    input  entry_t     wb_slot,
    output logic       blocked
);

    entry_t slots [3];

    assign slots[0] = exe_slot;
    assign slots[1] = mem_slot;
    assign slots[2] = wb_slot;

    // Youngest matching slot decides: a younger resolved writer shadows an older pending one.
    always_comb begin
        logic decided;
        blocked = 1'b0;
        decided = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!decided && (src != 5'd0) && slots[k].valid && (slots[k].rd == src)) begin
                blocked = unresolved(slots[k], 2'(k));
                decided = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_hazard_controller.sv
// Decode-stage interlock: tracks in-flight rd writers and stalls decode until operands can be forwarded.
// Latency: status outputs combinational (zero cycles); slots and stall counter update on the next edge.
// Backpressure: downstream JUMP beats downstream STALL beats interlock STALL; downstream STALL freezes slots.
module decode_hazard_controller
    import hazard::*;
    import pipeline_status::*;
#(
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid_in,
    input  logic [4:0]               issue_rd_in,
    input  logic                     issue_writes_rd_in,
    input  logic [1:0]               issue_result_stage_in,
    input  logic [4:0]               rs1_address_in,
    input  logic [4:0]               rs2_address_in,
    input  logic                     uses_rs1_in,
    input  logic                     uses_rs2_in,
    input  backwards_t               status_backwards_in,
    output backwards_t               status_backwards_out,
    output logic                     hazard_stall_out,
    output logic [COUNTER_WIDTH-1:0] stall_count_out
);

    entry_t exe_q, mem_q, wb_q;
    entry_t exe_d, mem_d, wb_d;
    entry_t new_entry;
    logic   rs1_blocked, rs2_blocked, hazard_hit;

    hazard_slot_match u_rs1_match (
        .src      (rs1_address_in),
        .exe_slot (exe_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .blocked  (rs1_blocked)
    );

    hazard_slot_match u_rs2_match (
        .src      (rs2_address_in),
        .exe_slot (exe_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .blocked  (rs2_blocked)
    );

    assign hazard_hit = issue_valid_in &&
                        ((uses_rs1_in && rs1_blocked) || (uses_rs2_in && rs2_blocked));

    // rd=x0 writers never enter the tracker; they can never cause an interlock.
    always_comb begin
        new_entry = EMPTY_ENTRY;
        if (issue_valid_in && issue_writes_rd_in && (issue_rd_in != 5'd0)) begin
            new_entry.valid        = 1'b1;
            new_entry.rd           = issue_rd_in;
            new_entry.result_stage = result_stage_t'(issue_result_stage_in);
        end
    end

    // Status priority and slot advance: JUMP and interlock bubble advance, downstream STALL holds.
    always_comb begin
        status_backwards_out = READY;
        hazard_stall_out     = 1'b0;
        exe_d                = exe_q;
        mem_d                = mem_q;
        wb_d                 = wb_q;
        if (status_backwards_in == JUMP) begin
            status_backwards_out = JUMP;
            wb_d  = mem_q;
            mem_d = exe_q;
            exe_d = EMPTY_ENTRY;
        end else if (status_backwards_in == STALL) begin
            status_backwards_out = STALL;
        end else if (hazard_hit) begin
            status_backwards_out = STALL;
            hazard_stall_out     = 1'b1;
            wb_d  = mem_q;
            mem_d = exe_q;
            exe_d = EMPTY_ENTRY;
        end else begin
            wb_d  = mem_q;
            mem_d = exe_q;
            exe_d = new_entry;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q <= EMPTY_ENTRY;
            mem_q <= EMPTY_ENTRY;
            wb_q  <= EMPTY_ENTRY;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Saturating count of interlock-caused stall cycles only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_out <= '0;
        end else if (hazard_stall_out && (stall_count_out != '1)) begin
            stall_count_out <= stall_count_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_controller.sv
// Directed bench for decode_hazard_controller: load-use, WB producers, masking, JUMP, downstream STALL, reset, saturation.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns later, well before the next edge.
// Backpressure: downstream status driven directly from the stimulus.
module tb_decode_hazard_controller;
    import hazard::*;
    import pipeline_status::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_writes_rd;
    logic [1:0]  issue_result_stage;
    logic [4:0]  rs1_address, rs2_address;
    logic        uses_rs1, uses_rs2;
    backwards_t  status_in;
    backwards_t  status_out, status_out4;
    logic        hazard_stall, hazard_stall4;
    logic [31:0] stall_count;
    logic [3:0]  stall_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_hazard_controller dut (
        .clk                   (clk),
        .rst                   (rst),
        .issue_valid_in        (issue_valid),
        .issue_rd_in           (issue_rd),
        .issue_writes_rd_in    (issue_writes_rd),
        .issue_result_stage_in (issue_result_stage),
        .rs1_address_in        (rs1_address),
        .rs2_address_in        (rs2_address),
        .uses_rs1_in           (uses_rs1),
        .uses_rs2_in           (uses_rs2),
        .status_backwards_in   (status_in),
        .status_backwards_out  (status_out),
        .hazard_stall_out      (hazard_stall),
        .stall_count_out       (stall_count)
    );

    decode_hazard_controller #(.COUNTER_WIDTH(4)) dut4 (
        .clk                   (clk),
        .rst                   (rst),
        .issue_valid_in        (issue_valid),
        .issue_rd_in           (issue_rd),
        .issue_writes_rd_in    (issue_writes_rd),
        .issue_result_stage_in (issue_result_stage),
        .rs1_address_in        (rs1_address),
        .rs2_address_in        (rs2_address),
        .uses_rs1_in           (uses_rs1),
        .uses_rs2_in           (uses_rs2),
        .status_backwards_in   (status_in),
        .status_backwards_out  (status_out4),
        .hazard_stall_out      (hazard_stall4),
        .stall_count_out       (stall_count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic instr(input logic v, input logic [4:0] rd, input logic wr, input logic [1:0] rs,
                         input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2);
        issue_valid        = v;
        issue_rd           = rd;
        issue_writes_rd    = wr;
        issue_result_stage = rs;
        rs1_address        = a1;
        uses_rs1           = u1;
        rs2_address        = a2;
        uses_rs2           = u2;
        #1;
    endtask

    task automatic idle();
        instr(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_status(input string tag, input backwards_t st, input logic hz);
        check({tag, "_status"}, 32'(status_out), 32'(st));
        check({tag, "_hazard"}, 32'(hazard_stall), 32'(hz));
    endtask

    task automatic flush();
        idle();
        repeat (3) step();
    endtask

    initial begin
        status_in = READY;
        idle();
        check("reset_status", 32'(status_out), 32'(READY));
        check("reset_hazard", 32'(hazard_stall), 32'd0);
        check("reset_count", stall_count, 32'd0);
        #3 rst = 1'b0;
        step();

        // Load-use: 1 stall.
        instr(1'b1, 5'd5, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_status("load_issue", READY, 1'b0);
        step();
        instr(1'b1, 5'd6, 1'b1, 2'd0, 5'd5, 1'b1, 5'd1, 1'b1);
        expect_status("loaduse_stall", STALL, 1'b1);
        check("loaduse_count0", stall_count, 32'd0);
        step();
        expect_status("loaduse_release", READY, 1'b0);
        check("loaduse_count1", stall_count, 32'd1);
        step();
        flush();

        // WB producer immediately behind: 2 stalls.
        instr(1'b1, 5'd7, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        instr(1'b1, 5'd8, 1'b1, 2'd0, 5'd7, 1'b1, 5'd0, 1'b0);
        expect_status("wb0_stall1", STALL, 1'b1);
        step();
        expect_status("wb0_stall2", STALL, 1'b1);
        step();
        expect_status("wb0_release", READY, 1'b0);
        check("wb0_count", stall_count, 32'd3);
        step();
        flush();

        // WB producer with one instruction between: 1 stall.
        instr(1'b1, 5'd7, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        instr(1'b1, 5'd9, 1'b1, 2'd0, 5'd1, 1'b1, 5'd2, 1'b1);
        expect_status("wb1_indep", READY, 1'b0);
        step();
        instr(1'b1, 5'd8, 1'b1, 2'd0, 5'd1, 1'b1, 5'd7, 1'b1);
        expect_status("wb1_stall", STALL, 1'b1);
        step();
        expect_status("wb1_release", READY, 1'b0);
        check("wb1_count", stall_count, 32'd4);
        step();
        flush();

        // Illegal stage encoding 3 behaves as WB.
        instr(1'b1, 5'd13, 1'b1, 2'd3, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        instr(1'b1, 5'd14, 1'b1, 2'd0, 5'd13, 1'b1, 5'd0, 1'b0);
        expect_status("stage3_stall1", STALL, 1'b1);
        step();
        expect_status("stage3_stall2", STALL, 1'b1);
        step();
        expect_status("stage3_release", READY, 1'b0);
        check("stage3_count", stall_count, 32'd6);
        step();
        flush();

        // rd=x0 producer never recorded; consumer reading x0 never stalls.
        instr(1'b1, 5'd0, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        instr(1'b1, 5'd11, 1'b1, 2'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        expect_status("x0_consumer", READY, 1'b0);
        step();
        flush();

        // Matching rs1 not used: no stall.
        instr(1'b1, 5'd10, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        instr(1'b1, 5'd11, 1'b1, 2'd0, 5'd10, 1'b0, 5'd1, 1'b1);
        expect_status("unused_rs1", READY, 1'b0);
        check("unused_count", stall_count, 32'd6);
        step();
        flush();

        // Younger resolved writer of x12 shadows the older pending one.
        instr(1'b1, 5'd12, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        instr(1'b1, 5'd12, 1'b1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        instr(1'b1, 5'd15, 1'b1, 2'd0, 5'd12, 1'b1, 5'd0, 1'b0);
        expect_status("shadowed", READY, 1'b0);
        step();
        flush();

        // JUMP over a pending hazard.
        instr(1'b1, 5'd5, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        instr(1'b1, 5'd6, 1'b1, 2'd0, 5'd5, 1'b1, 5'd0, 1'b0);
        status_in = JUMP;
        #1;
        expect_status("jump_out", JUMP, 1'b0);
        step();
        status_in = READY;
        #1;
        expect_status("jump_after", READY, 1'b0);
        check("jump_count", stall_count, 32'd6);
        step();
        flush();

        // Downstream STALL holds slots; one interlock stall afterwards.
        instr(1'b1, 5'd5, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        instr(1'b1, 5'd6, 1'b1, 2'd0, 5'd5, 1'b1, 5'd0, 1'b0);
        status_in = STALL;
        #1;
        for (int i = 0; i < 3; i++) begin
            expect_status($sformatf("ds_stall%0d", i), STALL, 1'b0);
            step();
        end
        status_in = READY;
        #1;
        expect_status("ds_interlock", STALL, 1'b1);
        step();
        expect_status("ds_release", READY, 1'b0);
        check("ds_count", stall_count, 32'd7);
        step();
        flush();

        // Asynchronous reset mid-stall.
        instr(1'b1, 5'd5, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        instr(1'b1, 5'd6, 1'b1, 2'd0, 5'd5, 1'b1, 5'd0, 1'b0);
        expect_status("rst_pre", STALL, 1'b1);
        #2 rst = 1'b1;
        #1;
        expect_status("rst_async", READY, 1'b0);
        check("rst_count", stall_count, 32'd0);
        #1 rst = 1'b0;
        #1;
        expect_status("rst_slots_clear", READY, 1'b0);
        step();
        flush();

        // Saturation: 2 stalls per pair, 4-bit counter caps at 15.
        for (int n = 0; n < 9; n++) begin
            instr(1'b1, 5'd7, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0);
            step();
            instr(1'b1, 5'd8, 1'b1, 2'd0, 5'd7, 1'b1, 5'd0, 1'b0);
            step();
            step();
            if (n == 6) check("sat_count4_14", 32'(stall_count4), 32'd14);
        end
        check("sat_count4_15", 32'(stall_count4), 32'd15);
        check("sat_count32_18", stall_count, 32'd18);
        check("sat_status", 32'(status_out4), 32'(READY));
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
